// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU op bit positions, divider state encoding and bus layouts for the execute stage.
package exe_stage_pkg;

    localparam int unsigned DS_TO_ES_BUS_WD = 153;
    localparam int unsigned ES_TO_MS_BUS_WD = 71;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned ALU_OP_WD       = 12;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 div_en;
        logic                 div_signed;
        logic                 div_rem;
        logic                 src1_is_pc;
        logic                 src2_is_imm;
        logic                 gr_we;
        logic                 mem_we;
        logic                 res_from_mem;
        logic [4:0]           dest;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      rj_value;
        logic [XLEN-1:0]      rkd_value;
        logic [XLEN-1:0]      pc;
    } ds_to_es_t;

    typedef struct packed {
        logic            res_from_mem;
        logic            gr_we;
        logic [4:0]      dest;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] pc;
    } es_to_ms_t;

    // Two's-complement magnitude when the value is treated as signed.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/exe_stage_iter_divider.sv
// Restoring divider: one quotient bit per cycle over 32 cycles on operand magnitudes, signs fixed up at the output.
module iter_divider
    import exe_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ack,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    div_state_e      state;
    logic [4:0]      cnt;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic            q_neg;
    logic            r_neg;
    logic            b_zero;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // dvd shifts dividend bits out of the top while quotient bits fill the bottom.
    always_comb begin
        shifted = {rem, dvd[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= DIV_IDLE;
            cnt    <= 5'd0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else if (start) begin
            state  <= DIV_BUSY;
            cnt    <= 5'd0;
            dvd    <= mag32(a, is_signed);
            dvs    <= mag32(b, is_signed);
            rem    <= '0;
            q_neg  <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg  <= is_signed & a[XLEN-1];
            b_zero <= (b == '0);
        end else begin
            case (state)
                DIV_BUSY: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        dvd <= {dvd[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        dvd <= {dvd[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        done      = (state == DIV_DONE);
        quotient  = b_zero ? '1 : (q_neg ? (~dvd + XLEN'(1)) : dvd);
        remainder = r_neg ? (~rem + XLEN'(1)) : rem;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches one decoded instruction, computes ALU or divide result, issues the data SRAM request on handoff.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [XLEN-1:0]            data_sram_addr,
    output logic [XLEN-1:0]            data_sram_wdata
);

    ds_to_es_t       in_bus;
    ds_to_es_t       es_bus;
    es_to_ms_t       out_bus;
    logic            es_valid;
    logic            es_ready_go;
    logic            load;
    logic            hs;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] alu_res;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;

    assign in_bus = ds_to_es_t'(ds_to_es_bus);

    // Handshake with decode and memory stages.
    always_comb begin
        es_ready_go    = !es_bus.div_en || div_done;
        es_allowin     = !es_valid || (es_ready_go && ms_allowin);
        es_to_ms_valid = es_valid && es_ready_go;
        hs             = es_to_ms_valid && ms_allowin;
        load           = ds_to_es_valid && es_allowin;
        in_src1        = in_bus.src1_is_pc  ? in_bus.pc  : in_bus.rj_value;
        in_src2        = in_bus.src2_is_imm ? in_bus.imm : in_bus.rkd_value;
        div_start      = load && in_bus.div_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            es_bus <= in_bus;
        end
    end

    // Divider captures operands on the same edge the instruction is latched.
    iter_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .ack       (hs),
        .is_signed (in_bus.div_signed),
        .a         (in_src1),
        .b         (in_src2),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        src1    = es_bus.src1_is_pc  ? es_bus.pc  : es_bus.rj_value;
        src2    = es_bus.src2_is_imm ? es_bus.imm : es_bus.rkd_value;
        sum     = src1 + src2;
        alu_res = '0;
        if (es_bus.alu_op[ALU_ADD])  alu_res = alu_res | sum;
        if (es_bus.alu_op[ALU_SUB])  alu_res = alu_res | (src1 - src2);
        if (es_bus.alu_op[ALU_SLT])  alu_res = alu_res | XLEN'($signed(src1) < $signed(src2));
        if (es_bus.alu_op[ALU_SLTU]) alu_res = alu_res | XLEN'(src1 < src2);
        if (es_bus.alu_op[ALU_AND])  alu_res = alu_res | (src1 & src2);
        if (es_bus.alu_op[ALU_NOR])  alu_res = alu_res | ~(src1 | src2);
        if (es_bus.alu_op[ALU_OR])   alu_res = alu_res | (src1 | src2);
        if (es_bus.alu_op[ALU_XOR])  alu_res = alu_res | (src1 ^ src2);
        if (es_bus.alu_op[ALU_SLL])  alu_res = alu_res | (src1 << src2[4:0]);
        if (es_bus.alu_op[ALU_SRL])  alu_res = alu_res | (src1 >> src2[4:0]);
        if (es_bus.alu_op[ALU_SRA])  alu_res = alu_res | XLEN'($signed(src1) >>> src2[4:0]);
        if (es_bus.alu_op[ALU_LUI])  alu_res = alu_res | src2;
    end

    always_comb begin
        out_bus.res_from_mem = es_bus.res_from_mem;
        out_bus.gr_we        = es_bus.gr_we;
        out_bus.dest         = es_bus.dest;
        out_bus.result       = es_bus.div_en ? (es_bus.div_rem ? div_r : div_q) : alu_res;
        out_bus.pc           = es_bus.pc;
        es_to_ms_bus         = out_bus;
        data_sram_en         = hs && (es_bus.mem_we || es_bus.res_from_mem);
        data_sram_we         = {4{hs && es_bus.mem_we}};
        data_sram_addr       = sum;
        data_sram_wdata      = es_bus.rkd_value;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU vector table plus divide, store stall, back-to-back and reset sequences.
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [152:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    typedef struct {
        logic [11:0] op;
        logic        s1pc;
        logic        s2imm;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs[13];

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    function automatic logic [152:0] mk(
        input logic [11:0] op,
        input logic div_en, input logic dsg, input logic drem,
        input logic s1pc, input logic s2imm,
        input logic gr_we, input logic mem_we, input logic rfm,
        input logic [4:0]  dest,
        input logic [31:0] imm, input logic [31:0] rj,
        input logic [31:0] rkd, input logic [31:0] pc);
        return {op, div_en, dsg, drem, s1pc, s2imm, gr_we, mem_we, rfm, dest, imm, rj, rkd, pc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic do_div(input string name, input logic sg, input logic rm,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int low;
        logic allow_bad;
        @(negedge clk);
        ds_to_es_bus   = mk(OP_ADD, 1'b1, sg, rm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'd0, a, b, 32'h1C00_0100);
        ds_to_es_valid = 1'b1;
        ms_allowin     = 1'b1;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        low       = 0;
        allow_bad = 1'b0;
        while (!es_to_ms_valid && low < 100) begin
            low++;
            if (es_allowin) allow_bad = 1'b1;
            @(posedge clk); #1;
        end
        chk({name, " low_cycles"}, 32'(low), 32'd32);
        chk({name, " allowin_low"}, {31'd0, allow_bad}, 32'd0);
        chk({name, " result"}, es_to_ms_bus[63:32], exp);
        chk({name, " sram_en"}, {31'd0, data_sram_en}, 32'd0);
        @(posedge clk); #1;
        chk({name, " drained"}, {31'd0, es_to_ms_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_ADD,  1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0,         32'h1,         32'h1C00_0000, 32'h8000_0000};
        vecs[1]  = '{OP_SUB,  1'b0, 1'b0, 32'd5,         32'd7,         32'h0,         32'h1C00_0004, 32'hFFFF_FFFE};
        vecs[2]  = '{OP_SLT,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h1C00_0008, 32'h1};
        vecs[3]  = '{OP_SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h1C00_000C, 32'h0};
        vecs[4]  = '{OP_AND,  1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'h1C00_0010, 32'hF000_F000};
        vecs[5]  = '{OP_NOR,  1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_000F, 32'h0,         32'h1C00_0014, 32'h0F0F_FFF0};
        vecs[6]  = '{OP_OR,   1'b0, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h0,         32'h1C00_0018, 32'h1234_5678};
        vecs[7]  = '{OP_XOR,  1'b0, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,         32'h1C00_001C, 32'hF0F0_0F0F};
        vecs[8]  = '{OP_SLL,  1'b0, 1'b0, 32'h0000_0001, 32'h0000_0024, 32'h0,         32'h1C00_0020, 32'h0000_0010};
        vecs[9]  = '{OP_SRL,  1'b0, 1'b0, 32'h8000_0000, 32'd31,        32'h0,         32'h1C00_0024, 32'h0000_0001};
        vecs[10] = '{OP_SRA,  1'b0, 1'b0, 32'h8000_0000, 32'd4,         32'h0,         32'h1C00_0028, 32'hF800_0000};
        vecs[11] = '{OP_LUI,  1'b0, 1'b1, 32'h0,         32'h0,         32'hABCD_E000, 32'h1C00_002C, 32'hABCD_E000};
        vecs[12] = '{OP_ADD,  1'b1, 1'b1, 32'h0,         32'h0,         32'h8,         32'h1C00_0000, 32'h1C00_0008};

        reset          = 1'b0;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #3;
        chk("reset es_allowin", {31'd0, es_allowin}, 32'd1);
        chk("reset es_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
        chk("reset sram_en", {31'd0, data_sram_en}, 32'd0);
        chk("reset sram_we", {28'd0, data_sram_we}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ALU vectors, issued back to back
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ds_to_es_bus = mk(vecs[i].op, 1'b0, 1'b0, 1'b0, vecs[i].s1pc, vecs[i].s2imm, 1'b1, 1'b0, 1'b0,
                              5'(i + 1), vecs[i].imm, vecs[i].rj, vecs[i].rkd, vecs[i].pc);
            ds_to_es_valid = 1'b1;
            @(posedge clk); #1;
            ds_to_es_valid = 1'b0;
            chk($sformatf("alu[%0d] valid", i), {31'd0, es_to_ms_valid}, 32'd1);
            chk($sformatf("alu[%0d] result", i), es_to_ms_bus[63:32], vecs[i].exp);
            chk($sformatf("alu[%0d] gr_we_dest", i), {26'd0, es_to_ms_bus[69:64]}, {26'd0, 1'b1, 5'(i + 1)});
            chk($sformatf("alu[%0d] pc", i), es_to_ms_bus[31:0], vecs[i].pc);
            chk($sformatf("alu[%0d] sram_en", i), {31'd0, data_sram_en}, 32'd0);
        end
        @(posedge clk); #1;
        chk("alu drained", {31'd0, es_to_ms_valid}, 32'd0);

        do_div("sdiv -7/2 q", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_div("sdiv -7/2 r", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_div("divu /0 q", 1'b0, 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        do_div("divu /0 r", 1'b0, 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234);
        do_div("sdiv min/-1 q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_div("sdiv min/-1 r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Store held by memory-stage backpressure
        @(negedge clk);
        ds_to_es_bus   = mk(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,
                            32'd4, 32'h100, 32'hDEAD_BEEF, 32'h1C00_0200);
        ds_to_es_valid = 1'b1;
        ms_allowin     = 1'b0;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk($sformatf("store stall[%0d] en", k), {31'd0, data_sram_en}, 32'd0);
            chk($sformatf("store stall[%0d] we", k), {28'd0, data_sram_we}, 32'd0);
            chk($sformatf("store stall[%0d] valid", k), {31'd0, es_to_ms_valid}, 32'd1);
        end
        ms_allowin = 1'b1;
        #1;
        chk("store en", {31'd0, data_sram_en}, 32'd1);
        chk("store we", {28'd0, data_sram_we}, 32'hF);
        chk("store addr", data_sram_addr, 32'h104);
        chk("store wdata", data_sram_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("store after en", {31'd0, data_sram_en}, 32'd0);
        chk("store after valid", {31'd0, es_to_ms_valid}, 32'd0);

        // Load then add, back to back
        @(negedge clk);
        ds_to_es_bus   = mk(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4,
                            32'h10, 32'h200, 32'h0, 32'h1C00_0300);
        ds_to_es_valid = 1'b1;
        @(posedge clk); #1;
        chk("load valid", {31'd0, es_to_ms_valid}, 32'd1);
        chk("load en", {31'd0, data_sram_en}, 32'd1);
        chk("load we", {28'd0, data_sram_we}, 32'd0);
        chk("load addr", data_sram_addr, 32'h210);
        chk("load res_from_mem", {31'd0, es_to_ms_bus[70]}, 32'd1);
        ds_to_es_bus = mk(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5,
                          32'h0, 32'd3, 32'd4, 32'h1C00_0304);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        chk("b2b add valid", {31'd0, es_to_ms_valid}, 32'd1);
        chk("b2b add en", {31'd0, data_sram_en}, 32'd0);
        chk("b2b add result", es_to_ms_bus[63:32], 32'd7);
        chk("b2b add pc", es_to_ms_bus[31:0], 32'h1C00_0304);
        @(posedge clk); #1;
        chk("b2b drained", {31'd0, es_to_ms_valid}, 32'd0);

        // Reset in the middle of a divide
        @(negedge clk);
        ds_to_es_bus   = mk(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9,
                            32'h0, 32'hFFFF_FFF9, 32'd2, 32'h1C00_0400);
        ds_to_es_valid = 1'b1;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("pre-reset busy allowin", {31'd0, es_allowin}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid-div reset es_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
        chk("mid-div reset es_allowin", {31'd0, es_allowin}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        do_div("post-reset divu 100/7 q", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        do_div("post-reset divu 100/7 r", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
